// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer: FSM state encoding and default widths.
package sample_sequencer_pkg;

  localparam int unsigned SampleSizeDefault   = 16;
  localparam int unsigned CntWidthDefault     = 8;
  localparam int unsigned TimeoutDefault      = 2048;
  localparam int unsigned HoldoffDefault      = 2;
  localparam int unsigned DecayShiftDefault   = 10;

  // Encodings are fixed so state values seen in waveforms match the documented numbering.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2,
    StWait  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sample_sequencer_peak.sv
// Decaying magnitude peak meter for captured engine results.
// The whole module exists only when SAMPLE_SEQ_PEAK_EN is defined, so a default build carries
// no peak logic at all.
`ifdef SAMPLE_SEQ_PEAK_EN
module peak_meter
  import sample_sequencer_pkg::*;
#(
  parameter int unsigned sample_size      = SampleSizeDefault,
  parameter int unsigned peak_decay_shift = DecayShiftDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic [sample_size-1:0] sample,
  output logic [sample_size-1:0] peak
);

  localparam logic [sample_size-1:0] MostNeg = {1'b1, {(sample_size-1){1'b0}}};
  localparam logic [sample_size-1:0] MostPos = {1'b0, {(sample_size-1){1'b1}}};

  logic [sample_size-1:0] mag;
  logic [sample_size-1:0] decayed;

  // Saturating magnitude of the new sample and the decayed previous peak.
  always_comb begin
    mag = sample;
    if (sample == MostNeg) begin
      mag = MostPos;
    end else if (sample[sample_size-1]) begin
      mag = -sample;
    end
    decayed = peak - (peak >> peak_decay_shift);
  end

  // Peak only moves on a successful capture; timed-out frames never reach here.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak <= '0;
    end else if (capture) begin
      peak <= (mag > decayed) ? mag : decayed;
    end
  end

endmodule
`endif

// File: rtl/sample_sequencer.sv
// Frame sequencer between the I2S transceiver and the DSP engine.
// Turns each rx_valid rising edge into one engine tick, buffers one pending frame, captures the
// engine result for transmit, and tracks overrun/timeout faults.
// Optional feature: define SAMPLE_SEQ_PEAK_EN to enable the decaying |tx_sample| peak meter.
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int unsigned sample_size      = SampleSizeDefault,
  parameter int unsigned cnt_width        = CntWidthDefault,
  parameter int unsigned timeout_cycles   = TimeoutDefault,
  parameter int unsigned ready_holdoff    = HoldoffDefault,
  parameter int unsigned peak_decay_shift = DecayShiftDefault
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [sample_size-1:0] rx_sample,
  output logic                   engine_tick,
  output logic [sample_size-1:0] engine_in,
  input  logic                   engine_ready,
  input  logic [sample_size-1:0] engine_out,
  output logic [sample_size-1:0] tx_sample,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout,
  output logic [cnt_width-1:0]   overrun_count,
  input  logic                   clear_stats,
  output logic [sample_size-1:0] peak
);

  localparam int unsigned CntMax = (timeout_cycles > ready_holdoff) ? timeout_cycles
                                                                     : ready_holdoff;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  if (peak_decay_shift >= sample_size) begin : gen_bad_shift
    $error("peak_decay_shift must be smaller than sample_size");
  end

  seq_state_e             state_q;
  logic                   rx_valid_q;
  logic [CntW-1:0]        wait_cnt_q;
  logic                   pending_full_q;
  logic [sample_size-1:0] pending_q;

  logic edge_det;
  logic capture;
  logic ov_evt;
  logic to_evt;

  assign busy = (state_q != StIdle);

  // Frame edge, capture and fault event decode.
  always_comb begin
    edge_det = rx_valid & ~rx_valid_q;
    capture  = (state_q == StWait) & engine_ready;
    // A drop only happens while busy; in IDLE the pending slot is drained the same cycle.
    ov_evt   = edge_det & (state_q != StIdle) & pending_full_q;
    to_evt   = (state_q == StWait) & ~engine_ready &
               (wait_cnt_q == CntW'(timeout_cycles - 1));
  end

  // Sequencer FSM with registered engine/tx outputs, pending buffer and sticky statistics.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= StIdle;
      rx_valid_q     <= 1'b0;
      wait_cnt_q     <= '0;
      pending_full_q <= 1'b0;
      pending_q      <= '0;
      engine_tick    <= 1'b0;
      engine_in      <= '0;
      tx_sample      <= '0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
      overrun_count  <= '0;
    end else begin
      rx_valid_q  <= rx_valid;
      engine_tick <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (pending_full_q) begin
            engine_in   <= pending_q;
            engine_tick <= 1'b1;
            state_q     <= StIssue;
            // A fresh edge refills the slot just drained, so it is not a drop.
            if (edge_det) begin
              pending_q <= rx_sample;
            end else begin
              pending_full_q <= 1'b0;
            end
          end else if (edge_det) begin
            engine_in   <= rx_sample;
            engine_tick <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= (ready_holdoff == 0) ? StWait : StHold;
        end
        StHold: begin
          if (wait_cnt_q == CntW'(ready_holdoff - 1)) begin
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StWait: begin
          if (engine_ready) begin
            tx_sample <= engine_out;
            state_q   <= StIdle;
          end else if (to_evt) begin
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (edge_det && (state_q != StIdle)) begin
        pending_q      <= rx_sample;
        pending_full_q <= 1'b1;
      end

      // clear_stats wins over any event in the same cycle.
      if (clear_stats) begin
        overrun       <= 1'b0;
        timeout       <= 1'b0;
        overrun_count <= '0;
      end else begin
        if (ov_evt) begin
          overrun <= 1'b1;
          if (overrun_count != '1) begin
            overrun_count <= overrun_count + 1'b1;
          end
        end
        if (to_evt) begin
          timeout <= 1'b1;
        end
      end
    end
  end

`ifdef SAMPLE_SEQ_PEAK_EN
  peak_meter #(
    .sample_size      (sample_size),
    .peak_decay_shift (peak_decay_shift)
  ) u_peak_meter (
    .clk     (sys_clk),
    .reset   (reset),
    .capture (capture),
    .sample  (engine_out),
    .peak    (peak)
  );
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed self-checking bench for sample_sequencer (default parameters).
module tb_sample_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [15:0] rx_sample;
  logic        engine_tick;
  logic [15:0] engine_in;
  logic        engine_ready;
  logic [15:0] engine_out;
  logic [15:0] tx_sample;
  logic        busy;
  logic        overrun;
  logic        timeout;
  logic [7:0]  overrun_count;
  logic        clear_stats;
  logic [15:0] peak;

  int checks = 0;
  int errors = 0;

  sample_sequencer dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_sample     (rx_sample),
    .engine_tick   (engine_tick),
    .engine_in     (engine_in),
    .engine_ready  (engine_ready),
    .engine_out    (engine_out),
    .tx_sample     (tx_sample),
    .busy          (busy),
    .overrun       (overrun),
    .timeout       (timeout),
    .overrun_count (overrun_count),
    .clear_stats   (clear_stats),
    .peak          (peak)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance n clock edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tick"}, 32'(engine_tick), 32'h0);
    check({tag, " engine_in"}, 32'(engine_in), 32'h0);
    check({tag, " tx_sample"}, 32'(tx_sample), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " overrun"}, 32'(overrun), 32'h0);
    check({tag, " timeout"}, 32'(timeout), 32'h0);
    check({tag, " count"}, 32'(overrun_count), 32'h0);
    check({tag, " peak"}, 32'(peak), 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_sample    = 16'h0;
    engine_ready = 1'b1;
    engine_out   = 16'h0;
    clear_stats  = 1'b0;
    cyc(2);
    check_all_zero("reset");
    reset = 1'b0;
    cyc(1);
    check("idle tick", 32'(engine_tick), 32'h0);

    // Single frame: edge at N, tick at N+1, ready 5 cycles after tick, tx one cycle later.
    rx_sample = 16'h1234;
    rx_valid  = 1'b1;
    cyc(1);
    check("single tick", 32'(engine_tick), 32'h1);
    check("single engine_in", 32'(engine_in), 32'h1234);
    check("single busy", 32'(busy), 32'h1);
    engine_ready = 1'b0;
    cyc(1);
    check("single tick one-shot", 32'(engine_tick), 32'h0);
    cyc(4);
    engine_ready = 1'b1;
    engine_out   = 16'h0F0F;
    check("single tx before", 32'(tx_sample), 32'h0);
    cyc(1);
    check("single tx", 32'(tx_sample), 32'h0F0F);
    check("single busy done", 32'(busy), 32'h0);
    rx_valid = 1'b0;
    cyc(1);

    // Back-to-back: second edge lands in WAIT and is issued after the first capture.
    rx_sample = 16'h1111;
    rx_valid  = 1'b1;
    cyc(1);
    check("b2b tick1", 32'(engine_tick), 32'h1);
    engine_ready = 1'b0;
    rx_valid     = 1'b0;
    cyc(3);
    rx_valid  = 1'b1;
    rx_sample = 16'h2222;
    cyc(1);
    check("b2b engine_in held", 32'(engine_in), 32'h1111);
    engine_ready = 1'b1;
    engine_out   = 16'h0AAA;
    cyc(1);
    check("b2b tx1", 32'(tx_sample), 32'h0AAA);
    check("b2b no tick yet", 32'(engine_tick), 32'h0);
    cyc(1);
    check("b2b tick2", 32'(engine_tick), 32'h1);
    check("b2b engine_in2", 32'(engine_in), 32'h2222);
    check("b2b overrun", 32'(overrun), 32'h0);
    engine_ready = 1'b0;
    rx_valid     = 1'b0;
    cyc(3);
    engine_ready = 1'b1;
    engine_out   = 16'h0BBB;
    cyc(1);
    check("b2b tx2", 32'(tx_sample), 32'h0BBB);

    // Overrun: three edges in one engine frame; the third sample wins.
    rx_sample = 16'h0101;
    rx_valid  = 1'b1;
    cyc(1);
    engine_ready = 1'b0;
    rx_valid     = 1'b0;
    cyc(1);
    rx_valid  = 1'b1;
    rx_sample = 16'h0202;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
    rx_valid  = 1'b1;
    rx_sample = 16'h0303;
    cyc(1);
    check("ovr flag", 32'(overrun), 32'h1);
    check("ovr count", 32'(overrun_count), 32'h1);
    rx_valid     = 1'b0;
    engine_ready = 1'b1;
    engine_out   = 16'h0C0C;
    cyc(1);
    check("ovr tx1", 32'(tx_sample), 32'h0C0C);
    cyc(1);
    check("ovr tick3", 32'(engine_tick), 32'h1);
    check("ovr engine_in3", 32'(engine_in), 32'h0303);
    cyc(3);
    engine_out = 16'h0D0D;
    cyc(1);
    check("ovr tx3", 32'(tx_sample), 32'h0D0D);

    // Saturation: one fill plus 256 drops in a single long frame.
    rx_sample = 16'h0E0E;
    rx_valid  = 1'b1;
    cyc(1);
    engine_ready = 1'b0;
    for (int i = 0; i < 257; i++) begin
      rx_valid = 1'b0;
      cyc(1);
      rx_valid  = 1'b1;
      rx_sample = 16'(i);
      cyc(1);
    end
    rx_valid = 1'b0;
    check("sat count", 32'(overrun_count), 32'hFF);
    check("sat busy", 32'(busy), 32'h1);
    engine_ready = 1'b1;
    engine_out   = 16'h1357;
    cyc(1);
    check("sat tx", 32'(tx_sample), 32'h1357);
    engine_ready = 1'b0;

    // Timeout on the pending frame: flag appears at tick + 1 + holdoff + 2048.
    cyc(1);
    check("to tick", 32'(engine_tick), 32'h1);
    check("to engine_in", 32'(engine_in), 32'h0100);
    cyc(2050);
    check("to not yet", 32'(timeout), 32'h0);
    check("to busy before", 32'(busy), 32'h1);
    cyc(1);
    check("to flag", 32'(timeout), 32'h1);
    check("to busy after", 32'(busy), 32'h0);
    check("to tx held", 32'(tx_sample), 32'h1357);
    clear_stats = 1'b1;
    cyc(1);
    check("clr timeout", 32'(timeout), 32'h0);
    check("clr overrun", 32'(overrun), 32'h0);
    check("clr count", 32'(overrun_count), 32'h0);
    clear_stats = 1'b0;

    // Holdoff: ready already high, capture must wait until WAIT.
    engine_ready = 1'b1;
    engine_out   = 16'h5555;
    rx_sample    = 16'h4444;
    rx_valid     = 1'b1;
    cyc(1);
    check("hold tick", 32'(engine_tick), 32'h1);
    cyc(2);
    check("hold tx early", 32'(tx_sample), 32'h1357);
    cyc(1);
    check("hold tx wait", 32'(tx_sample), 32'h1357);
    check("hold busy", 32'(busy), 32'h1);
    cyc(1);
    check("hold tx", 32'(tx_sample), 32'h5555);
    rx_valid = 1'b0;
    cyc(1);

    // clear_stats in the same cycle as an overrun event leaves the stats cleared.
    engine_ready = 1'b0;
    rx_sample    = 16'h0707;
    rx_valid     = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
    rx_valid  = 1'b1;
    rx_sample = 16'h0717;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
    rx_valid    = 1'b1;
    rx_sample   = 16'h0727;
    clear_stats = 1'b1;
    cyc(1);
    check("clr beats ovr flag", 32'(overrun), 32'h0);
    check("clr beats ovr count", 32'(overrun_count), 32'h0);
    clear_stats  = 1'b0;
    rx_valid     = 1'b0;
    engine_ready = 1'b1;
    engine_out   = 16'h0808;
    cyc(1);
    check("clr tx", 32'(tx_sample), 32'h0808);
    cyc(1);
    check("clr pending engine_in", 32'(engine_in), 32'h0727);
    cyc(4);
    check("clr busy done", 32'(busy), 32'h0);

    // Reset while in WAIT aborts everything.
    engine_ready = 1'b0;
    rx_sample    = 16'h6666;
    rx_valid     = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(3);
    check("rst pre busy", 32'(busy), 32'h1);
    reset = 1'b1;
    cyc(1);
    check_all_zero("rst wait");
    reset = 1'b0;
    cyc(1);
    check("rst after tick", 32'(engine_tick), 32'h0);
    check("rst after busy", 32'(busy), 32'h0);

    // Peak: most-negative sample saturates, then decays on the next capture.
    rx_sample    = 16'h8000;
    engine_out   = 16'h8000;
    engine_ready = 1'b1;
    rx_valid     = 1'b1;
    cyc(1);
    check("peak engine_in", 32'(engine_in), 32'h8000);
    rx_valid = 1'b0;
    cyc(4);
    check("peak tx", 32'(tx_sample), 32'h8000);
`ifdef SAMPLE_SEQ_PEAK_EN
    check("peak sat", 32'(peak), 32'h7FFF);
`else
    check("peak off", 32'(peak), 32'h0);
`endif
    rx_sample  = 16'h0001;
    engine_out = 16'h0001;
    rx_valid   = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(4);
    check("decay tx", 32'(tx_sample), 32'h0001);
`ifdef SAMPLE_SEQ_PEAK_EN
    check("peak decay", 32'(peak), 32'h7FE0);
`else
    check("peak off 2", 32'(peak), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
